// File: rtl/coin_return_dispenser.sv
// coin_return_dispenser
// Returns a requested amount as a sequence of coins, largest usable coin
// first, drawing on a per-coin inventory that customer deposits top up.
//
// Handshakes:
//   start : i_start is taken only while o_ready=1 (IDLE). A start edge latches
//           i_return_amount and the block goes busy until its o_done pulse.
//   coin  : o_return_coin is a one-hot "valid" held stable until the coin
//           mechanism answers with i_coin_ack=1 at an edge. That edge consumes
//           the coin. i_coin_ack is ignored whenever no coin is presented.
module coin_return_dispenser #(
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000,
    parameter int CNT_BITS   = 8,
    parameter int INIT_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [15:0]           i_return_amount,
    input  logic                  i_coin_ack,
    input  logic [2:0]            i_deposit_coin,
    output logic [2:0]            o_return_coin,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [15:0]           o_remainder,
    output logic [2:0]            o_empty,
    output logic [1:0]            dbg_state
);

    // Widths shared with the rest of the vending machine
    // (kNumCoins / kTotalBits in vending_machine_def.v).
    localparam int kNumCoins  = 3;
    localparam int kTotalBits = 16;

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [kTotalBits-1:0]  remaining_q;
    logic [CNT_BITS-1:0]    count_q [kNumCoins];
    logic [1:0]             disp_idx_q;
    logic                   cand_found;
    logic [1:0]             cand_idx;
    logic                   ack_fire;

    // Face value of a coin index, truncated to the amount width.
    function automatic logic [kTotalBits-1:0] coin_value(input logic [1:0] idx);
        logic [kTotalBits-1:0] v;
        case (idx)
            2'd0:    v = kTotalBits'(COIN0_VAL);
            2'd1:    v = kTotalBits'(COIN1_VAL);
            2'd2:    v = kTotalBits'(COIN2_VAL);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Coin consumed at this edge: only meaningful while presenting one.
    assign ack_fire = (state_q == DISPENSE) && i_coin_ack;

    // Highest-index coin that still fits the remaining amount and is in stock;
    // later loop iterations override earlier ones, so the top index wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = 2'd0;
        for (int i = 0; i < kNumCoins; i++) begin
            if ((coin_value(2'(i)) <= remaining_q) && (count_q[i] != '0)) begin
                cand_found = 1'b1;
                cand_idx   = 2'(i);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                state_d = cand_found ? DISPENSE : DONE;
            end
            DISPENSE: begin
                if (i_coin_ack) begin
                    state_d = SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remaining amount, presented coin and reported remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q   <= '0;
            o_return_coin <= '0;
            o_remainder   <= '0;
            disp_idx_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        remaining_q <= i_return_amount;
                    end
                end
                SELECT: begin
                    if (cand_found) begin
                        o_return_coin <= kNumCoins'(1) << cand_idx;
                        disp_idx_q    <= cand_idx;
                    end else begin
                        // Nothing more can be paid out: publish what is left.
                        // It stays on o_remainder until the next completion.
                        o_remainder <= remaining_q;
                    end
                end
                DISPENSE: begin
                    if (i_coin_ack) begin
                        // The candidate rule guarantees no underflow here.
                        remaining_q   <= remaining_q - coin_value(disp_idx_q);
                        o_return_coin <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Inventory counters: deposits saturate upward, acknowledged coins count
    // down, and a deposit of the very coin being taken cancels it out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < kNumCoins; i++) begin
                count_q[i] <= CNT_INIT;
            end
        end else begin
            for (int i = 0; i < kNumCoins; i++) begin
                if (i_deposit_coin[i] && ack_fire && (disp_idx_q == 2'(i))) begin
                    count_q[i] <= count_q[i];
                end else if (i_deposit_coin[i]) begin
                    if (count_q[i] != CNT_MAX) begin
                        count_q[i] <= count_q[i] + 1'b1;
                    end
                end else if (ack_fire && (disp_idx_q == 2'(i))) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
            end
        end
    end

    // Per-coin stock-out flags, straight off the counters.
    always_comb begin
        for (int i = 0; i < kNumCoins; i++) begin
            o_empty[i] = (count_q[i] == '0);
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_done    = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Directed bench for coin_return_dispenser: a table of full return
// transactions plus hand-written stall, reset, deposit and saturation cases.
module tb_coin_return_dispenser;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [15:0] i_return_amount;
  logic        i_coin_ack;
  logic [2:0]  i_deposit_coin;
  logic [2:0]  o_return_coin;
  logic        o_ready;
  logic        o_done;
  logic [15:0] o_remainder;
  logic [2:0]  o_empty;
  logic [1:0]  dbg_state;

  int n_pass;
  int n_total;

  logic [2:0] exp_q[$];

  typedef struct {
    bit          do_reset;
    logic [15:0] amount;
    int          n2;
    int          n1;
    int          n0;
    logic [15:0] rem;
    logic [2:0]  empty;
  } vec_t;

  coin_return_dispenser dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_return_amount (i_return_amount),
    .i_coin_ack      (i_coin_ack),
    .i_deposit_coin  (i_deposit_coin),
    .o_return_coin   (o_return_coin),
    .o_ready         (o_ready),
    .o_done          (o_done),
    .o_remainder     (o_remainder),
    .o_empty         (o_empty),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full return with i_coin_ack held high; expected coins go into the
  // scoreboard queue, largest coins first.
  task automatic run_return(input logic [15:0] amt, input int n2, input int n1, input int n0,
                            input logic [15:0] rem, input logic [2:0] empty);
    int cyc;
    int first;
    bit done;
    logic [2:0] e;
    exp_q.delete();
    repeat (n2) exp_q.push_back(3'b100);
    repeat (n1) exp_q.push_back(3'b010);
    repeat (n0) exp_q.push_back(3'b001);
    check("ready_before_start", {31'd0, o_ready}, 32'd1);
    i_return_amount = amt;
    i_start = 1'b1;
    i_coin_ack = 1'b1;
    cyc = 0;
    first = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
      if (o_return_coin != 3'b000) begin
        if (first == 0) first = cyc;
        if (exp_q.size() == 0) begin
          check("extra_coin", {29'd0, o_return_coin}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("coin", {29'd0, o_return_coin}, {29'd0, e});
        end
      end
      if (o_done) begin
        done = 1'b1;
        if (first == 0) first = cyc;
      end
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("first_event_latency", first, 2);
    check("coins_missing", exp_q.size(), 0);
    check("remainder", {16'd0, o_remainder}, {16'd0, rem});
    check("empty", {29'd0, o_empty}, {29'd0, empty});
    @(negedge clk);
    check("done_one_cycle", {31'd0, o_done}, 32'd0);
    check("ready_after_done", {31'd0, o_ready}, 32'd1);
    check("remainder_held", {16'd0, o_remainder}, {16'd0, rem});
    i_coin_ack = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int waited;
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    i_start = 1'b0;
    i_return_amount = '0;
    i_coin_ack = 1'b0;
    i_deposit_coin = 3'b000;

    vecs[0] = '{1'b1, 16'd1600, 1, 1, 1, 16'd0,    3'b000};
    vecs[1] = '{1'b0, 16'd6500, 3, 3, 3, 16'd1700, 3'b111};
    vecs[2] = '{1'b1, 16'd6500, 4, 4, 4, 16'd100,  3'b111};
    vecs[3] = '{1'b1, 16'd150,  0, 0, 1, 16'd50,   3'b000};
    vecs[4] = '{1'b0, 16'd0,    0, 0, 0, 16'd0,    3'b000};
    vecs[5] = '{1'b0, 16'd2300, 2, 0, 3, 16'd0,    3'b001};
    vecs[6] = '{1'b0, 16'd600,  0, 1, 0, 16'd100,  3'b001};
    vecs[7] = '{1'b0, 16'd99,   0, 0, 0, 16'd99,   3'b001};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_coin", {29'd0, o_return_coin}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_remainder", {16'd0, o_remainder}, 32'd0);
    check("rst_empty", {29'd0, o_empty}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // table-driven transactions
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_reset) do_reset();
      run_return(vecs[v].amount, vecs[v].n2, vecs[v].n1, vecs[v].n0, vecs[v].rem, vecs[v].empty);
    end

    // stalled coin, ignored start, then reset mid-dispense
    do_reset();
    run_return(16'd150, 0, 0, 1, 16'd50, 3'b000);
    i_coin_ack = 1'b0;
    i_return_amount = 16'd1000;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    check("stall_coin_first", {29'd0, o_return_coin}, 32'd4);
    for (int k = 0; k < 5; k++) begin
      i_start = 1'b1;
      i_return_amount = 16'd500;
      @(negedge clk);
      check("stall_coin_held", {29'd0, o_return_coin}, 32'd4);
      check("stall_not_ready", {31'd0, o_ready}, 32'd0);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_coin", {29'd0, o_return_coin}, 32'd0);
    check("async_rst_ready", {31'd0, o_ready}, 32'd1);
    check("async_rst_remainder", {16'd0, o_remainder}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_done_after_rst", {31'd0, o_done}, 32'd0);
    end
    run_return(16'd6500, 4, 4, 4, 16'd100, 3'b111);

    // deposit and acknowledge of coin 0 on the same edge
    do_reset();
    i_return_amount = 16'd100;
    i_start = 1'b1;
    i_coin_ack = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    check("dep_ack_coin", {29'd0, o_return_coin}, 32'd1);
    i_coin_ack = 1'b1;
    i_deposit_coin = 3'b001;
    @(negedge clk);
    i_coin_ack = 1'b0;
    i_deposit_coin = 3'b000;
    check("dep_ack_cleared", {29'd0, o_return_coin}, 32'd0);
    waited = 0;
    while (!o_done && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("dep_ack_done", {31'd0, o_done}, 32'd1);
    check("dep_ack_remainder", {16'd0, o_remainder}, 32'd0);
    @(negedge clk);
    run_return(16'd400, 0, 0, 4, 16'd0, 3'b001);

    // saturation of coin 0 inventory
    do_reset();
    i_deposit_coin = 3'b001;
    repeat (300) @(negedge clk);
    i_deposit_coin = 3'b000;
    run_return(16'd31600, 4, 4, 255, 16'd100, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/coin_return_dispenser.md
COIN_RETURN_DISPENSER -- requirements
Module: coin_return_dispenser

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and reset (asynchronous, active-high).
REQ-002 The block SHALL take widths kNumCoins (3) and kTotalBits from vending_machine_def.v.
REQ-003 Parameters, one per line (name, default, meaning):
 - COIN0_VAL, 100, value of coin index 0.
 - COIN1_VAL, 500, value of coin index 1.
 - COIN2_VAL, 1000, value of coin index 2.
 - CNT_BITS, 8, width of each per-coin inventory counter.
 - INIT_COUNT, 4, reset value of each inventory counter.
REQ-004 Ports, one per line (name, direction, width, meaning):
 - clk, in, 1, clock.
 - reset, in, 1, async active-high reset.
 - i_start, in, 1, request to return i_return_amount.
 - i_return_amount, in, kTotalBits, amount to be returned.
 - i_coin_ack, in, 1, coin mechanism has taken the presented coin.
 - i_deposit_coin, in, kNumCoins, one-hot coin inserted by a customer; adds to inventory.
 - o_return_coin, out, kNumCoins, one-hot coin presented for ejection.
 - o_ready, out, 1, IDLE, start accepted.
 - o_done, out, 1, one-cycle completion pulse.
 - o_remainder, out, kTotalBits, amount left unreturned at completion.
 - o_empty, out, kNumCoins, per-coin inventory count is 0.

Function
REQ-005 The FSM SHALL have the states IDLE, SELECT, DISPENSE and DONE, all registered.
REQ-006 In IDLE, o_ready SHALL be 1; in all other states o_ready SHALL be 0.
REQ-007 In IDLE, when i_start=1 at an edge, the block SHALL latch remaining <= i_return_amount and move to SELECT.
REQ-008 In any state other than IDLE, i_start SHALL be ignored.
REQ-009 In SELECT, the candidate SHALL be the highest-index coin with value <= remaining and count > 0.
 - If a candidate exists, the next edge SHALL register o_return_coin to that one-hot coin and move to DISPENSE.
 - If no candidate exists (including remaining = 0), the next edge SHALL move to DONE.
REQ-010 In DISPENSE, o_return_coin SHALL be held stable until i_coin_ack=1 at an edge; there is no timeout.
REQ-011 At that acknowledging edge, the block SHALL:
 - subtract the coin value from remaining;
 - decrement the coin's count;
 - clear o_return_coin to 0;
 - move to SELECT.
REQ-012 i_coin_ack SHALL be ignored outside DISPENSE.
REQ-013 In DONE, o_done SHALL be 1 for exactly one cycle, o_remainder SHALL equal remaining, and the next state SHALL be IDLE.
REQ-014 o_remainder SHALL hold its value until the next DONE.
REQ-015 Latency SHALL be fixed:
 - start edge to first coin visible: 2 edges;
 - each coin: at least 2 cycles (SELECT plus DISPENSE);
 - amount 0: o_done high in the 2nd cycle after the start edge.
REQ-016 i_deposit_coin SHALL increment the addressed count every edge, in any state, saturating at 2^CNT_BITS-1.
REQ-017 When a deposit and an acknowledged dispense hit the same coin in the same edge, that count SHALL be unchanged.
REQ-018 Subtraction SHALL be kTotalBits unsigned arithmetic; remaining never underflows because of the candidate rule.
REQ-019 o_empty[i] SHALL be a combinational (count[i] == 0).
REQ-020 o_return_coin SHALL never have more than one bit set.

Reset
REQ-021 On reset (asynchronous, any state), the block SHALL immediately set:
 - state to IDLE;
 - o_return_coin, o_done, o_remainder and remaining to 0;
 - every count to INIT_COUNT;
 - o_ready to 1 and o_empty to 0.
REQ-022 A reset asserted mid-operation SHALL abandon the return; no o_done SHALL be produced for it.

Verification
REQ-023 Reset with the default parameters -> o_ready=1, o_return_coin=000, o_done=0, o_remainder=0, o_empty=000.
REQ-024 Start with 1600, i_coin_ack tied 1 -> coins 100 (index 2), then 010, then 001; o_done pulse; o_remainder=0; counts 3/3/3.
REQ-025 After reset, start with 6500 -> 4x1000, 4x500, 4x100; o_remainder=100; o_empty=111.
REQ-026 Start with 150 -> one 001 coin; o_remainder=50. Start with 0 -> no coin; o_done in the 2nd cycle after start; o_remainder=0.
REQ-027 Start with 1000 and hold i_coin_ack=0 for 5 cycles -> o_return_coin stays 100 and i_start is ignored. Then assert reset mid-DISPENSE -> o_return_coin=000 at once, no o_done, counts back to 4.
REQ-028 In DISPENSE of coin 0, assert i_coin_ack=1 and i_deposit_coin=001 in the same cycle -> count0 unchanged. Repeated deposits -> count saturates at 255.
